// File: rtl/haraka_pkg.sv
// Shared GF(2^8) helpers, column geometry and FSM state type for the Haraka-S
// MixColumns / InvMixColumns blocks.
package haraka_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using an xtime chain; enough for 01..0F.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational single-column InvMixColumns; row 0 is the MSB byte.
// With MIXCOL_FWD_MODE_EN defined, a fwd input selects forward MixColumns.
module inv_mix_column
  import haraka_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
`ifdef MIXCOL_FWD_MODE_EN
  input  logic             fwd,
`endif
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] inv[4];

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign a[i]  = col_i[COL_W-1-8*i -: 8];
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);

    // 0E, 0B, 0D, 09 composed from the shared doubling chain
    assign inv[i] = (x8[i] ^ x4[i] ^ x2[i])
                  ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                  ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                  ^ (x8[(i+3)%4] ^ a[(i+3)%4]);

`ifdef MIXCOL_FWD_MODE_EN
    logic [7:0] fw;
    assign fw = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
    assign col_o[COL_W-1-8*i -: 8] = fwd ? fw : inv[i];
`else
    assign col_o[COL_W-1-8*i -: 8] = inv[i];
`endif
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns engine with valid/ready on both sides.
// Optional MIXCOL_FWD_MODE_EN adds a fwd port selecting forward MixColumns.
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready=1
//   BUSY  | transforming COLS_PER_CYCLE columns per clock in place
//   DONE  | result held on out_data until out_ready
module inv_mix_columns_seq
  import haraka_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_data,
`ifdef MIXCOL_FWD_MODE_EN
  input  logic                      fwd,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_data
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

  imc_state_t                  state_q, state_d;
  logic [1:0]                  col_cnt_q, col_cnt_d;
  logic [NUM_COLS*COL_W-1:0]   work_q, work_d;
`ifdef MIXCOL_FWD_MODE_EN
  logic                        fwd_q, fwd_d;
`endif

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [6:0]       col_base[COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    // col_cnt is always a multiple of COLS_PER_CYCLE, so the 2-bit sum never wraps early
    assign col_idx[k]  = col_cnt_q + 2'(k);
    assign col_base[k] = {~col_idx[k], 5'b0};
    assign col_in[k]   = work_q[col_base[k] +: COL_W];

    inv_mix_column u_col (
      .col_i (col_in[k]),
`ifdef MIXCOL_FWD_MODE_EN
      .fwd   (fwd_q),
`endif
      .col_o (col_out[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
`ifdef MIXCOL_FWD_MODE_EN
    fwd_d     = fwd_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          work_d    = in_data;
          col_cnt_d = 2'd0;
`ifdef MIXCOL_FWD_MODE_EN
          fwd_d     = fwd;
`endif
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[col_base[k] +: COL_W] = col_out[k];
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
`ifdef MIXCOL_FWD_MODE_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
`ifdef MIXCOL_FWD_MODE_EN
      fwd_q     <= fwd_d;
`endif
    end
  end

  assign out_data = work_q;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Column-serial, iterative AES InvMixColumns engine for the Haraka-S datapath.
- Exact inverse of the team's combinational MixColumns block, with the same byte and column ordering.
- Provides the inverse direction for round-trip checking and for inverse-permutation experiments.
- Accepts one 128-bit state via valid/ready, processes COLS_PER_CYCLE 32-bit columns per clock, and returns the result via valid/ready.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  input state.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  128  InvMixColumns(in_data).

Interface notes:
- One clock; reset is synchronous and active-high.

Behaviour:
- Ordering: column c = bits [127-32c : 96-32c]. Row 0 of each column is the MSB byte.
- Per column: out_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3), indices mod 4, arithmetic in GF(2^8) mod 0x11B. Multiplies are built from xtime chains; no lookup ROMs.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data, clear col_cnt, go to BUSY.
  - BUSY: each cycle transform columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place, then col_cnt += COLS_PER_CYCLE. On the cycle that finishes column 3, go to DONE.
  - DONE: out_valid=1. out_data is held stable until out_ready. On out_ready, go to IDLE.
- Latency: out_valid rises 4/COLS_PER_CYCLE clocks after the accept edge.
- Throughput: one state per 4/COLS_PER_CYCLE + 2 clocks when out_ready is held high.
- in_ready=0 in BUSY and DONE. in_valid during those states is ignored and no data is captured.
- in_data may change freely after the accept edge.
- out_data shows the working register. It is guaranteed valid only while out_valid=1.
- col_cnt wraps to 0 on the transition to DONE. It never indexes beyond column 3.
- Simultaneous out_ready and in_valid in DONE: the result is handed off and the FSM goes to IDLE. The new input is NOT taken that cycle because in_ready=0.
- Reset values: in_ready=0 during reset and 1 in the first cycle after reset; out_valid=0; out_data=0; state=IDLE; col_cnt=0.
- Reset mid-BUSY or mid-DONE: the operation is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro name: MIXCOL_FWD_MODE_EN.
- When defined:
  - Adds input port `fwd` (1 bit), sampled with in_data on the accept edge.
  - fwd=1 selects forward MixColumns coefficients (02,03,01,01), reusing the xtime chains; fwd=0 selects inverse.
- When undefined: no `fwd` port, inverse only, and the forward coefficient muxes are absent.

Decomposition:
- haraka_pkg holds:
  - the xtime and gf_mul functions;
  - the COL_W=32 and NUM_COLS=4 constants;
  - the enum typedef imc_state_t {IDLE, BUSY, DONE}.
- Sub-module inv_mix_column: combinational, 32-bit in / 32-bit out, plus the `fwd` input when the macro is defined. Instantiated COLS_PER_CYCLE times.

Test Plan:
1. in_data=128'hc2384d1874b136ad378e6bfa95432594, COLS_PER_CYCLE=1 -> out_data=128'h87F24D976E4C90EC46E74AC3A68CD895, with out_valid exactly 4 clocks after accept.
2. in_data={4{32'h046681e5}} -> {4{32'hd4bf5d30}}. In addition, all-zero -> all-zero and {4{32'h01010101}} -> {4{32'h01010101}}.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_data stable, in_ready=0, and a pulsed in_valid in that window is ignored.
4. Assert rst in the 2nd BUSY cycle. Required: out_valid never rises, and in_ready=1 in the first cycle after rst drops. A subsequent vector then completes correctly.
5. COLS_PER_CYCLE=2 and =4: back-to-back random stream chained through MixColumns -> this block. Required: round-trip equals input, with latencies 2 and 1 respectively.
6. With MIXCOL_FWD_MODE_EN, fwd=1, in_data=128'h87F24D976E4C90EC46E74AC3A68CD895 -> 128'hc2384d1874b136ad378e6bfa95432594.
